// File: rtl/lfsr_engine_if.sv
// ---------------------------------------------------------------------------
// lfsr_engine_if : method-handshake bundle for lfsr_engine | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lfsr_engine_if #(
  parameter int LN    = 8,
  parameter int STEPW = 8
);
  logic             load__ENA;
  logic [LN-1:0]    load__v;
  logic             load__RDY;
  logic             shiftBit__ENA;
  logic             shiftBit__v;
  logic             shiftBit__RDY;
  logic             run__ENA;
  logic [STEPW-1:0] run__n;
  logic             run__RDY;
  logic             result__ENA;
  logic [LN-1:0]    result;
  logic             result__RDY;
  logic             outBit;
  logic             outBit__RDY;
  logic             stuck;

  modport master (
    output load__ENA, load__v, shiftBit__ENA, shiftBit__v,
           run__ENA, run__n, result__ENA,
    input  load__RDY, shiftBit__RDY, run__RDY, result, result__RDY,
           outBit, outBit__RDY, stuck
  );

  modport slave (
    input  load__ENA, load__v, shiftBit__ENA, shiftBit__v,
           run__ENA, run__n, result__ENA,
    output load__RDY, shiftBit__RDY, run__RDY, result, result__RDY,
           outBit, outBit__RDY, stuck
  );
endinterface

`default_nettype wire

// File: rtl/lfsr_engine.sv
// ---------------------------------------------------------------------------
// lfsr_engine : Fibonacci/Galois LFSR with seed load, single step and
//               autonomous multi-step run with result handshake | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_engine #(
  parameter int              LN     = 8,
  parameter logic [LN-1:0]   TAPS   = 8'h1D,
  parameter bit              GALOIS = 1'b0,
  parameter int              STEPW  = 8,
  parameter logic [LN-1:0]   SEED   = {{(LN-1){1'b0}}, 1'b1}
) (
  input  wire logic    CLK,
  input  wire logic    nRST,
  lfsr_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [STEPW-1:0] c_one = {{(STEPW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [LN-1:0]    sreg_q,  sreg_d;
  logic [STEPW-1:0] rem_q,   rem_d;

  function automatic logic [LN-1:0] lfsr_step(input logic [LN-1:0] s, input logic i);
    logic fb;
    logic g;
    if (GALOIS) begin
      g = s[0] ^ i;
      return (s >> 1) ^ (g ? TAPS : '0);
    end else begin
      fb = (^(s & TAPS)) ^ i;
      return {fb, s[LN-1:1]};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        // load beats run beats shiftBit; losers in the same cycle are dropped
        if (bus.load__ENA) begin
          sreg_d = bus.load__v;
        end else if (bus.run__ENA) begin
          if (bus.run__n == '0) begin
            state_d = S_DONE;
          end else begin
            rem_d   = bus.run__n;
            state_d = S_RUN;
          end
        end else if (bus.shiftBit__ENA) begin
          sreg_d = lfsr_step(sreg_q, bus.shiftBit__v);
        end
      end
      S_RUN: begin
        sreg_d = lfsr_step(sreg_q, 1'b0);
        rem_d  = rem_q - c_one;
        if (rem_q == c_one) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.result__ENA) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      sreg_q  <= SEED;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
    end
  end

  // Handshake outputs decode state only, so no ENA reaches a RDY combinationally
  assign bus.load__RDY     = (state_q == S_IDLE);
  assign bus.shiftBit__RDY = (state_q == S_IDLE);
  assign bus.run__RDY      = (state_q == S_IDLE);
  assign bus.result__RDY   = (state_q == S_DONE);
  assign bus.result        = sreg_q;
  assign bus.outBit        = sreg_q[0];
  assign bus.outBit__RDY   = 1'b1;
  assign bus.stuck         = (sreg_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_lfsr_engine.sv
// ---------------------------------------------------------------------------
// tb_lfsr_engine : directed self-checking bench for lfsr_engine | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lfsr_engine;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  lfsr_engine_if #(.LN(8), .STEPW(8)) fif ();
  lfsr_engine_if #(.LN(8), .STEPW(8)) gif ();

  lfsr_engine #(.LN(8), .TAPS(8'h1D), .GALOIS(1'b0), .STEPW(8), .SEED(8'h01)) u_fib (
    .CLK (CLK),
    .nRST(nRST),
    .bus (fif.slave)
  );

  lfsr_engine #(.LN(8), .TAPS(8'hB8), .GALOIS(1'b1), .STEPW(8), .SEED(8'h01)) u_gal (
    .CLK (CLK),
    .nRST(nRST),
    .bus (gif.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic fib_load(input logic [7:0] v);
    fif.load__ENA = 1'b1; fif.load__v = v;
    cyc(1);
    fif.load__ENA = 1'b0;
  endtask

  task automatic fib_shift(input logic v);
    fif.shiftBit__ENA = 1'b1; fif.shiftBit__v = v;
    cyc(1);
    fif.shiftBit__ENA = 1'b0;
  endtask

  task automatic gal_shift(input logic v);
    gif.shiftBit__ENA = 1'b1; gif.shiftBit__v = v;
    cyc(1);
    gif.shiftBit__ENA = 1'b0;
  endtask

  task automatic fib_take();
    fif.result__ENA = 1'b1;
    cyc(1);
    fif.result__ENA = 1'b0;
  endtask

  // Start a run and wait (bounded) for result__RDY; reports cycles after acceptance
  task automatic fib_run(input logic [7:0] n, output logic [7:0] res,
                         output int cycles, output logic stuck_seen);
    fif.run__ENA = 1'b1; fif.run__n = n;
    cyc(1);
    fif.run__ENA = 1'b0;
    cycles = 0; stuck_seen = 1'b0;
    while (!fif.result__RDY && cycles < 300) begin
      if (fif.stuck) stuck_seen = 1'b1;
      cyc(1);
      cycles++;
    end
    res = fif.result;
  endtask

  logic [7:0] res;
  int         cycles;
  logic       stuck_seen;
  logic       flag;
  logic [7:0] run_exp [4];

  initial begin
    run_exp = '{8'h80, 8'h40, 8'h20, 8'h10};
    fif.load__ENA = 0; fif.load__v = 0; fif.shiftBit__ENA = 0; fif.shiftBit__v = 0;
    fif.run__ENA = 0; fif.run__n = 0; fif.result__ENA = 0;
    gif.load__ENA = 0; gif.load__v = 0; gif.shiftBit__ENA = 0; gif.shiftBit__v = 0;
    gif.run__ENA = 0; gif.run__n = 0; gif.result__ENA = 0;

    cyc(2);
    chk("rst_result_rdy", fif.result__RDY, 0);
    chk("rst_load_rdy", fif.load__RDY, 1);
    chk("rst_run_rdy", fif.run__RDY, 1);
    chk("rst_shift_rdy", fif.shiftBit__RDY, 1);
    chk("rst_outbit", fif.outBit, 1);
    chk("rst_outbit_rdy", fif.outBit__RDY, 1);
    chk("rst_stuck", fif.stuck, 0);
    chk("rst_sreg", fif.result, 8'h01);
    nRST = 1'b1;
    cyc(1);

    // Run of 5 from 0x01, with load/shiftBit hammered while running
    fib_load(8'h01);
    fif.run__ENA = 1'b1; fif.run__n = 8'd5;
    cyc(1);
    fif.run__ENA = 1'b0;
    chk("run_rdy_busy", fif.run__RDY, 0);
    fif.load__ENA = 1'b1; fif.load__v = 8'h55;
    fif.shiftBit__ENA = 1'b1; fif.shiftBit__v = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc(1);
      chk($sformatf("run5_step%0d", j + 1), fif.result, run_exp[j]);
      chk($sformatf("run5_nordy%0d", j + 1), fif.result__RDY, 0);
      chk($sformatf("run5_load_rdy%0d", j + 1), fif.load__RDY | fif.shiftBit__RDY, 0);
    end
    cyc(1);
    chk("run5_done_rdy", fif.result__RDY, 1);
    chk("run5_result", fif.result, 8'h88);
    fif.load__ENA = 1'b0; fif.shiftBit__ENA = 1'b0;

    flag = 1'b1;
    for (int j = 0; j < 10; j++) begin
      cyc(1);
      if (fif.result !== 8'h88 || fif.result__RDY !== 1'b1) flag = 1'b0;
    end
    chk("done_hold_stable", flag, 1);
    fib_take();
    chk("take_idle", fif.run__RDY, 1);
    chk("take_rdy_low", fif.result__RDY, 0);

    // Full period and one step short
    fib_load(8'h01);
    fib_run(8'd255, res, cycles, stuck_seen);
    chk("period255_result", res, 8'h01);
    chk("period255_latency", cycles, 255);
    chk("period255_stuck", stuck_seen, 0);
    fib_take();
    fib_run(8'd254, res, cycles, stuck_seen);
    chk("period254_result", res, 8'h02);
    chk("period254_stuck", stuck_seen, 0);
    fib_take();

    // All-zero register, escape via shiftBit, zero-length run
    fib_load(8'h00);
    chk("zero_stuck", fif.stuck, 1);
    fib_shift(1'b1);
    chk("zero_shift_sreg", fif.result, 8'h80);
    chk("zero_shift_stuck", fif.stuck, 0);
    fib_run(8'd0, res, cycles, stuck_seen);
    chk("run0_latency", cycles, 0);
    chk("run0_result", res, 8'h80);
    fib_take();

    // Same-cycle load/run/shiftBit: load wins, stays idle
    fif.load__ENA = 1'b1; fif.load__v = 8'h55;
    fif.run__ENA = 1'b1; fif.run__n = 8'd3;
    fif.shiftBit__ENA = 1'b1; fif.shiftBit__v = 1'b1;
    cyc(1);
    fif.load__ENA = 1'b0; fif.run__ENA = 1'b0; fif.shiftBit__ENA = 1'b0;
    chk("prio_sreg", fif.result, 8'h55);
    chk("prio_idle", fif.run__RDY, 1);
    cyc(4);
    chk("prio_no_done", fif.result__RDY, 0);
    chk("prio_sreg_hold", fif.result, 8'h55);

    // Galois single steps
    gif.load__ENA = 1'b1; gif.load__v = 8'h01;
    cyc(1);
    gif.load__ENA = 1'b0;
    chk("gal_outbit0", gif.outBit, 1);
    gal_shift(1'b0);
    chk("gal_step1", gif.result, 8'hB8);
    chk("gal_outbit1", gif.outBit, 0);
    gal_shift(1'b0);
    chk("gal_step2", gif.result, 8'h5C);
    chk("gal_outbit2", gif.outBit, 0);

    // Reset three steps into a 10-step run
    fib_load(8'h37);
    fif.run__ENA = 1'b1; fif.run__n = 8'd10;
    cyc(1);
    fif.run__ENA = 1'b0;
    cyc(3);
    nRST = 1'b0;
    cyc(1);
    nRST = 1'b1;
    chk("rstrun_idle", fif.run__RDY, 1);
    chk("rstrun_sreg", fif.result, 8'h01);
    chk("rstrun_rdy", fif.result__RDY, 0);
    flag = 1'b0;
    for (int j = 0; j < 15; j++) begin
      cyc(1);
      if (fif.result__RDY) flag = 1'b1;
    end
    chk("rstrun_no_done", flag, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
